// File: rtl/branch_sequencer.sv
// branch_sequencer: fetch PC owner, branch comparator and redirect/trap sequencer between decode and fetch
// Ports: clk, rst (sync, active-high); stall, op_valid/op_ready handshake; op_type, funct3, rs1, rs2, imm
// describe one control-flow op; pc, link/link_valid, redirect are registered results; trap/trap_addr/trap_ack
// handle misaligned targets; br_count/br_taken_count are statistics, live only with BRANCH_SEQ_STATS_EN defined.
module branch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_type,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] imm,
    output logic [31:0] pc,
    output logic [31:0] link,
    output logic        link_valid,
    output logic        redirect,
    output logic        trap,
    output logic [31:0] trap_addr,
    input  logic        trap_ack,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);
    typedef enum logic {RUN, TRAP} state_t;
    state_t state, state_nx;
    logic        accept, is_br, eq, slt, ult, taken, nonseq, misal;
    logic [31:0] target, seq;
    assign accept = op_valid && op_ready;
    assign is_br  = op_type == 2'b01;
    assign eq     = rs1 == rs2;
    assign slt    = $signed(rs1) < $signed(rs2);
    assign ult    = rs1 < rs2;
    // funct3[0] inverts the base compare; funct3[2:1]=01 is reserved and never taken
    assign taken  = funct3[2] ? ((funct3[1] ? ult : slt) ^ funct3[0]) : (!funct3[1] && (eq ^ funct3[0]));
    assign nonseq = op_type[1] || (is_br && taken);
    assign target = (op_type == 2'b11) ? ((rs1 + imm) & ~32'h1) : (pc + imm);
    assign seq    = pc + 32'd4;
    assign misal  = nonseq && target[1];
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == RUN && accept && misal) state_nx = TRAP;
        if (state == TRAP && trap_ack) state_nx = RUN;
    end
    always_comb begin
        op_ready = state == RUN && !stall;
        trap     = state == TRAP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            link       <= '0;
            link_valid <= 1'b0;
            redirect   <= 1'b0;
            trap_addr  <= '0;
        end else begin
            link_valid <= 1'b0;
            redirect   <= 1'b0;
            if (state == TRAP && trap_ack) begin
                pc       <= TRAP_VECTOR;
                redirect <= 1'b1;
            end else if (accept) begin
                if (misal) trap_addr <= target;
                else if (nonseq) begin
                    pc       <= target;
                    redirect <= 1'b1;
                    if (op_type[1]) begin
                        link       <= seq;
                        link_valid <= 1'b1;
                    end
                end else pc <= seq;
            end
        end
    end
`ifdef BRANCH_SEQ_STATS_EN
    // taken-but-misaligned branches still count as taken
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else if (accept && is_br) begin
            br_count       <= br_count + 32'd1;
            br_taken_count <= br_taken_count + {31'd0, taken};
        end
    end
`else
    assign br_count       = '0;
    assign br_taken_count = '0;
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: scoreboard bench for branch_sequencer
module tb_branch_sequencer;
    logic        clk = 0, rst = 0, stall = 0, op_valid = 0, trap_ack = 0;
    logic [1:0]  op_type = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] rs1 = 0, rs2 = 0, imm = 0;
    logic        op_ready, link_valid, redirect, trap;
    logic [31:0] pc, link, trap_addr, br_count, br_taken_count;
    branch_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .op_valid(op_valid), .op_ready(op_ready),
        .op_type(op_type), .funct3(funct3), .rs1(rs1), .rs2(rs2), .imm(imm),
        .pc(pc), .link(link), .link_valid(link_valid), .redirect(redirect),
        .trap(trap), .trap_addr(trap_addr), .trap_ack(trap_ack),
        .br_count(br_count), .br_taken_count(br_taken_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] pc, link, taddr, brc, btc;
        logic        lv, rd, tr;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    logic [31:0] m_pc, m_link, m_taddr, m_brc, m_btc;
    logic        m_trap;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask
    task automatic push(input logic lv, input logic rd);
        exp_t e;
        e.pc = m_pc; e.link = m_link; e.taddr = m_taddr; e.lv = lv; e.rd = rd; e.tr = m_trap;
`ifdef BRANCH_SEQ_STATS_EN
        e.brc = m_brc; e.btc = m_btc;
`else
        e.brc = 0; e.btc = 0;
`endif
        sb.push_back(e);
    endtask
    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".pc"}, pc, e.pc);
        check({tag, ".link"}, link, e.link);
        check({tag, ".lv"}, {31'd0, link_valid}, {31'd0, e.lv});
        check({tag, ".redir"}, {31'd0, redirect}, {31'd0, e.rd});
        check({tag, ".trap"}, {31'd0, trap}, {31'd0, e.tr});
        check({tag, ".taddr"}, trap_addr, e.taddr);
        check({tag, ".brc"}, br_count, e.brc);
        check({tag, ".btc"}, br_taken_count, e.btc);
    endtask
    task automatic do_reset(input string tag);
        rst = 1; op_valid = 1; trap_ack = 1; op_type = 2'b10; imm = 32'h40;
        m_pc = 0; m_link = 0; m_taddr = 0; m_brc = 0; m_btc = 0; m_trap = 0;
        push(0, 0);
        @(posedge clk); #1;
        rst = 0; op_valid = 0; trap_ack = 0;
        compare(tag);
        check({tag, ".rdy"}, {31'd0, op_ready}, 32'd1);
    endtask
    task automatic step(input string tag, input logic v, input logic s, input logic [1:0] t,
                        input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic ack);
        logic tk, lv, rd;
        logic [31:0] tgt, sum;
        op_valid = v; stall = s; op_type = t; funct3 = f; rs1 = a; rs2 = b; imm = i; trap_ack = ack;
        #1;
        check({tag, ".rdy"}, {31'd0, op_ready}, {31'd0, !m_trap && !s});
        lv = 0; rd = 0;
        if (m_trap) begin
            if (ack) begin m_pc = 32'h100; rd = 1; m_trap = 0; end
        end else if (v && !s) begin
            case (t)
                2'b00: tk = 0;
                2'b01: case (f)
                    3'b000: tk = a == b;
                    3'b001: tk = a != b;
                    3'b100: tk = $signed(a) < $signed(b);
                    3'b101: tk = $signed(a) >= $signed(b);
                    3'b110: tk = a < b;
                    3'b111: tk = a >= b;
                    default: tk = 0;
                endcase
                default: tk = 1;
            endcase
            sum = a + i;
            tgt = (t == 2'b11) ? {sum[31:1], 1'b0} : m_pc + i;
            if (t == 2'b01) begin m_brc++; if (tk) m_btc++; end
            if (tk && tgt[1]) begin m_trap = 1; m_taddr = tgt; end
            else if (tk) begin
                rd = 1;
                if (t[1]) begin m_link = m_pc + 4; lv = 1; end
                m_pc = tgt;
            end else m_pc = m_pc + 4;
        end
        push(lv, rd);
        @(posedge clk); #1;
        op_valid = 0; stall = 0; trap_ack = 0;
        compare(tag);
    endtask
    task automatic go(input logic [31:0] addr);
        step("go", 1, 0, 2'b11, 0, addr, 0, 0, 0);
    endtask
    initial begin
        @(posedge clk); #1;
        do_reset("rst");
        step("seq1", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        step("seq2", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        step("seq3", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        go(32'h100);
        step("blt", 1, 0, 2'b01, 3'b100, 32'hFFFF_FFFF, 1, 32'h20, 0);
        go(32'h100);
        step("bltu", 1, 0, 2'b01, 3'b110, 32'hFFFF_FFFF, 1, 32'h20, 0);
        go(32'h200);
        step("jalr", 1, 0, 2'b11, 0, 32'h1001, 0, 4, 0);
        step("idle", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("beq", 1, 0, 2'b01, 3'b000, 7, 7, 32'hFFFF_FFF0, 0);
        step("bne", 1, 0, 2'b01, 3'b001, 7, 7, 32'h10, 0);
        step("bge", 1, 0, 2'b01, 3'b101, 1, 32'h8000_0000, 32'h8, 0);
        step("bgeu", 1, 0, 2'b01, 3'b111, 1, 32'h8000_0000, 32'h8, 0);
        step("f010", 1, 0, 2'b01, 3'b010, 1, 1, 32'h6, 0);
        for (int k = 0; k < 6; k++)
            step("rand", 1, $urandom_range(0, 1), 2'b01, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3), $urandom_range(0, 3), {$urandom_range(0, 15), 3'b000}, 0);
        go(32'h40);
        step("jalmis", 1, 0, 2'b10, 0, 0, 0, 6, 0);
        step("trapop", 1, 1, 2'b10, 0, 0, 0, 8, 0);
        step("trapop2", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        step("ack", 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("ackrun", 0, 0, 2'b00, 0, 0, 0, 0, 1);
        step("stall", 1, 1, 2'b01, 3'b000, 5, 5, 32'h40, 0);
        go(32'hFFFF_FFFC);
        step("wrap", 1, 0, 2'b00, 0, 0, 0, 0, 0);
        step("brmis", 1, 0, 2'b01, 3'b000, 3, 3, 32'h6, 0);
        step("jalrmis", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        do_reset("rsttrap");
        go(32'h0);
        step("jalrm", 1, 0, 2'b11, 0, 32'h3, 0, 0, 0);
        do_reset("rst2");
        step("b1", 1, 0, 2'b01, 3'b000, 1, 1, 8, 0);
        step("b2", 1, 0, 2'b01, 3'b001, 1, 2, 8, 0);
        step("b3", 1, 0, 2'b01, 3'b110, 1, 2, 8, 0);
        step("b4", 1, 0, 2'b01, 3'b111, 1, 2, 8, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer that owns the fetch PC and drives the conditional-branch comparator. It accepts one decoded control-flow operation per handshake and evaluates the branch condition (funct3 semantics BEQ/BNE/BLT/BGE/BLTU/BGEU). It computes the next PC, pulses a redirect/flush on non-sequential flow, and traps on misaligned targets. It sits between decode and fetch in the core.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded when a trap is acknowledged.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset: synchronous, active-high; overrides all other inputs.
- stall  in  1  holds PC; deasserts op_ready in RUN.
- op_valid  in  1  operation offered.
- op_ready  out  1  sequencer can accept; equals (state==RUN && !stall).
- op_type  in  2  00 sequential, 01 conditional branch, 10 JAL, 11 JALR.
- funct3  in  3  branch condition, used only when op_type=01.
- rs1, rs2  in  32 each  register operands.
- imm  in  32  sign-extended offset.
- pc  out  32  current PC (registered).
- link  out  32  PC+4 of accepted JAL/JALR.
- link_valid  out  1  one-cycle pulse, link valid.
- redirect  out  1  one-cycle pulse, PC changed non-sequentially (fetch flush).
- trap  out  1  level, high while in TRAP.
- trap_addr  out  32  offending misaligned target.
- trap_ack  in  1  acknowledges trap.
- br_count, br_taken_count  out  32 each  statistics (see Configuration).

## Operation
- States: RUN, TRAP. Reset state RUN.
- Accept = op_valid && op_ready. Without accept, all registers hold and pulses are 0.
- Target computation, all modulo 2^32:
  - branch/JAL target = pc + imm.
  - JALR target = (rs1 + imm) & ~32'h1.
  - seq = pc + 4.
- Branch taken per funct3:
  - 000 eq, 001 ne.
  - 100 signed lt, 101 signed ge.
  - 110 unsigned lt, 111 unsigned ge.
  - 010/011: not taken, treated as sequential, no trap.
- Next PC:
  - sequential or not-taken branch: seq.
  - taken branch, JAL, JALR: target.
- Misaligned: a taken/jump target with bit[1]=1 causes:
  - pc holds; trap_addr <= target; state -> TRAP; redirect=0.
  - link_valid still 0 (no link write).
  - Not-taken branches never trap.
- Valid non-sequential accept: pc <= target, redirect=1 next cycle. JAL/JALR additionally set link <= pc+4 and link_valid=1 next cycle.
- TRAP state:
  - op_ready=0; stall is ignored.
  - On trap_ack: pc <= TRAP_VECTOR, trap_addr holds, redirect=1 next cycle, state -> RUN.
- trap_ack in RUN is ignored.

## Timing
- Reset values: pc=RESET_PC; state RUN. All other outputs reset to 0: link, link_valid, redirect, trap, trap_addr, and the counters.
- Latency: accept at edge N -> pc/link/redirect/link_valid visible after edge N (one cycle).
- op_ready is combinational from state and stall. Next-PC logic is combinational from inputs; all outputs are registered except op_ready.
- Back-to-back accepts allowed every cycle; each uses the pc value updated by the previous accept.
- stall and op_valid together: no accept, pc holds.
- Reset mid-TRAP, or together with trap_ack/accept: reset wins, returns to RUN with reset values.
- Wrap: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000, no trap.

## Configuration
- BRANCH_SEQ_STATS_EN defined:
  - br_count increments on every accepted op_type=01.
  - br_taken_count increments on every accepted taken branch, including taken-but-misaligned.
  - Both counters are 32-bit wrapping and reset to 0.
- BRANCH_SEQ_STATS_EN undefined: ports remain, tied to 0, no counter logic.

## Test plan
- Reset with RESET_PC=0: pc=0, trap=0. Sequential op accepted 3 cycles -> pc=4, 8, 12; redirect stays 0.
- pc=0x100, BLT rs1=0xFFFF_FFFF, rs2=1, imm=0x20 -> taken (signed), pc=0x120, redirect=1. Same operands with BLTU -> not taken, pc=0x104.
- pc=0x200, JALR rs1=0x1001, imm=4 -> pc=0x1004, link=0x204, link_valid=1, redirect=1 for one cycle.
- pc=0x40, JAL imm=0x6 -> trap=1, trap_addr=0x46, pc stays 0x40, op_ready=0. trap_ack -> pc=TRAP_VECTOR (0x100), redirect=1, trap=0.
- stall=1 with op_valid=1 BEQ equal operands -> pc unchanged, op_ready=0. rst during TRAP -> pc=RESET_PC, trap=0.
- With BRANCH_SEQ_STATS_EN: 4 branches accepted, 3 taken -> br_count=4, br_taken_count=3. Without the macro -> both 0.
